// File: rtl/nibble_serial_adder.sv
// Serial wide adder: feeds an external 4-bit full adder one nibble per clock and
// assembles the wide sum. Optional signed-overflow flag via `OVERFLOW_FLAG_EN.
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int W      = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
`ifdef OVERFLOW_FLAG_EN
  output logic         ovf,
`endif
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_carry
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [W-1:0]  a_q, b_q, result_q;
  logic          carry_q, cout_q;
  logic [CW-1:0] cnt_q;
  logic          last_nib;
`ifdef OVERFLOW_FLAG_EN
  logic          ovf_q;
`endif

  assign last_nib = (cnt_q == CW'(NIBBLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q      <= a_in;
          b_q      <= b_in;
          carry_q  <= cin_in;
          result_q <= '0;
          cnt_q    <= '0;
          state_q  <= RUN;
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++)
            if (cnt_q == CW'(i)) result_q[i*4 +: 4] <= add_sum;
          carry_q <= add_carry;
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          cnt_q   <= cnt_q + 1'b1;
          if (last_nib) begin
            cout_q  <= add_carry;
`ifdef OVERFLOW_FLAG_EN
            // Low nibble of the shift regs is the most significant pair here.
            ovf_q   <= (a_q[3] == b_q[3]) && (add_sum[3] != a_q[3]);
`endif
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Adder operands come only from registers and are gated to zero outside RUN.
  assign add_a   = (state_q == RUN) ? a_q[3:0] : 4'h0;
  assign add_b   = (state_q == RUN) ? b_q[3:0] : 4'h0;
  assign add_cin = (state_q == RUN) ? carry_q  : 1'b0;

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit
// full adder on the add_* side.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        cin_in = 1'b0;
  logic        busy, done, cout;
  logic [15:0] result;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_carry;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .busy(busy), .done(done), .result(result), .cout(cout),
`ifdef OVERFLOW_FLAG_EN
    .ovf(ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept start at edge 0, then watch edges 1..8 for the done pulse.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] exp_res, input logic exp_co);
    int nd, lat;
    logic [15:0] res;
    logic co;
    nd = 0; lat = -1; res = 'x; co = 1'bx;
    a_in = a; b_in = b; cin_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (done) begin
        nd++;
        if (lat < 0) lat = e;
        res = result;
        co  = cout;
      end
    end
    chk({tag, "_ndone"}, nd, 1);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_cout"}, co, exp_co);
    chk({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int nd;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("t3", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("t3b", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1);
    run_op("t3c", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

    // Start re-pulsed at edges 2..4 with different operands must be ignored.
    a_in = 16'h1234; b_in = 16'h4321; cin_in = 1'b0; start = 1'b1;
    tick();                                   // edge 0
    start = 1'b0;
    tick();                                   // edge 1
    chk("t4_busy1", busy, 1);
    chk("t4_adda", add_a, 4'h3);
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b1; start = 1'b1;
    nd = 0;
    for (int e = 2; e <= 4; e++) begin
      tick();
      if (done) nd++;
    end
    chk("t4_done_e4", done, 1);
    chk("t4_busy_done", busy, 1);
    tick();                                   // edge 5
    if (done) nd++;
    chk("t4_ndone", nd, 1);
    chk("t4_res", result, 16'h5555);
    chk("t4_cout", cout, 0);
    chk("t4_idle_e5", busy, 0);
    a_in = 16'h0001; b_in = 16'h0002; cin_in = 1'b0;
    tick();                                   // edge 6: accepted
    start = 1'b0;
    chk("t4_accept_e6", busy, 1);
    chk("t4_adda_new", add_a, 4'h1);
    for (int e = 7; e <= 10; e++) tick();
    chk("t4_new_done", done, 1);
    chk("t4_new_res", result, 16'h0003);
    tick();

    // Async reset mid-run: outputs clear immediately, no done pulse follows.
    a_in = 16'h1111; b_in = 16'h1111; cin_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_result", result, 0);
    chk("t5_cout", cout, 0);
    chk("t5_add", {add_a, add_b, add_cin}, 0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (done || busy) nd++;
    end
    chk("t5_no_done", nd, 0);
    run_op("t5_after", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

`ifdef OVERFLOW_FLAG_EN
    run_op("t6a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    chk("t6a_ovf", ovf, 1);
    run_op("t6b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    chk("t6b_ovf", ovf, 0);
    run_op("t6c", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    chk("t6c_ovf", ovf, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
